// File: rtl/pri_arb_enc_if.sv
// pri_arb_enc_if
//   Bundle of request-side and result-side signals for pri_arb_enc.
//   slave  : the arbiter (consumes req/mode/out_ready[/lock], drives results)
//   master : the surrounding logic (drives req/mode/out_ready[/lock])
//   Signals:
//     req        N  request vector, bit i = requester i
//     mode       1  0 = fixed priority, 1 = round-robin
//     out_ready  1  consumer accepts the current result
//     out_valid  1  out_idx/out_onehot hold a winner
//     out_idx    W  binary index of the winner
//     out_onehot N  one-hot winner
//     any        1  registered OR of req, never frozen
//     lock       1  present only when PRI_ARB_LOCK_EN is defined
interface pri_arb_enc_if #(
  parameter int N = 8
);
  localparam int W = $clog2(N);

  logic [N-1:0] req;
  logic         mode;
  logic         out_ready;
  logic         out_valid;
  logic [W-1:0] out_idx;
  logic [N-1:0] out_onehot;
  logic         any;
`ifdef PRI_ARB_LOCK_EN
  logic         lock;
`endif

  modport slave (
    input  req, mode, out_ready,
`ifdef PRI_ARB_LOCK_EN
    input  lock,
`endif
    output out_valid, out_idx, out_onehot, any
  );

  modport master (
    output req, mode, out_ready,
`ifdef PRI_ARB_LOCK_EN
    output lock,
`endif
    input  out_valid, out_idx, out_onehot, any
  );
endinterface

// File: rtl/pri_arb_enc.sv
// pri_arb_enc
//   Registered N-input priority encoder / arbiter. Picks one winner per
//   arbitration, either fixed priority (highest index wins) or round-robin
//   (cyclic descending search from an internal pointer), and presents the
//   winner on a valid/ready stage that holds under backpressure.
//   Optional feature macro: PRI_ARB_LOCK_EN adds the lock input, which pins
//   the grant on the last winner for as long as it keeps requesting.
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    pri_arb_enc_if.slave (req, mode, out_ready[, lock] in;
//            out_valid, out_idx, out_onehot, any out)
module pri_arb_enc #(
  parameter  int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  pri_arb_enc_if.slave    bus
);

  localparam logic [W-1:0] PTR_INIT = W'(N - 1);
  localparam logic [N-1:0] ONE_N    = N'(1);

  logic         vld_p1;
  logic [W-1:0] idx_p1;
  logic [N-1:0] onehot_p1;
  logic         any_p1;
  logic [W-1:0] ptr_p1;

  logic         arb_en;
  logic         found;
  logic         lock_hit;
  logic [W-1:0] fix_idx;
  logic [W-1:0] rr_idx;
  logic [W-1:0] win_idx;

  // The stage may load a new result when it is empty or being drained.
  assign arb_en = !vld_p1 || bus.out_ready;
  assign found  = |bus.req;

`ifdef PRI_ARB_LOCK_EN
  logic         lk_vld_p1;
  logic [W-1:0] lk_idx_p1;
  assign lock_hit = lk_vld_p1 && bus.req[lk_idx_p1];
`else
  assign lock_hit = 1'b0;
`endif

  always_comb begin
    int j;
    fix_idx = '0;
    rr_idx  = '0;
    j       = 0;
    // Ascending scan: the last set bit seen is the highest index.
    for (int i = 0; i < N; i++) begin
      if (bus.req[i]) fix_idx = W'(i);
    end
    // Visit candidates from farthest (ptr-(N-1)) to nearest (ptr) so the
    // final assignment is the first hit of the descending cyclic search.
    // The wrap adds N, so non-power-of-two N never aliases to unused codes.
    for (int d = N - 1; d >= 0; d--) begin
      j = int'(ptr_p1) - d;
      if (j < 0) j = j + N;
      if (bus.req[j]) rr_idx = W'(j);
    end
  end

`ifdef PRI_ARB_LOCK_EN
  assign win_idx = lock_hit ? lk_idx_p1 : (bus.mode ? rr_idx : fix_idx);
`else
  assign win_idx = bus.mode ? rr_idx : fix_idx;
`endif

  // ---- stage p1: registered result, pointer and request summary ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1    <= 1'b0;
      idx_p1    <= '0;
      onehot_p1 <= '0;
      any_p1    <= 1'b0;
      ptr_p1    <= PTR_INIT;
    end else begin
      any_p1 <= found;
      if (arb_en) begin
        vld_p1    <= found;
        idx_p1    <= found ? win_idx : '0;
        onehot_p1 <= found ? (ONE_N << win_idx) : '0;
        // A locked re-grant bypasses the rotation entirely.
        if (found && bus.mode && !lock_hit) begin
          ptr_p1 <= (win_idx == '0) ? PTR_INIT : win_idx - W'(1);
        end
      end
    end
  end

`ifdef PRI_ARB_LOCK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lk_vld_p1 <= 1'b0;
      lk_idx_p1 <= '0;
    end else if (arb_en) begin
      lk_vld_p1 <= found && bus.lock;
      lk_idx_p1 <= win_idx;
    end
  end
`endif

  assign bus.out_valid  = vld_p1;
  assign bus.out_idx    = idx_p1;
  assign bus.out_onehot = onehot_p1;
  assign bus.any        = any_p1;

endmodule

// File: tb/tb_pri_arb_enc.sv
module tb_pri_arb_enc;

  typedef struct {
    logic vld;
    int   idx;
    int   oh;
    logic any;
  } exp_t;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  exp_t q4[$];
  exp_t q5[$];

  // Reference state, index 0 = N=4 instance, index 1 = N=5 instance.
  logic m_vld[2];
  int   m_idx[2];
  int   m_ptr[2];
  logic m_lk[2];
  int   m_lkidx[2];

  pri_arb_enc_if #(.N(4)) if4 ();
  pri_arb_enc_if #(.N(5)) if5 ();

  pri_arb_enc #(.N(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));
  pri_arb_enc #(.N(5)) dut5 (.clk(clk), .rst_n(rst_n), .bus(if5));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      m_vld[u]   = 1'b0;
      m_idx[u]   = 0;
      m_ptr[u]   = (u == 0) ? 3 : 4;
      m_lk[u]    = 1'b0;
      m_lkidx[u] = 0;
    end
  endtask

  // Behavioural arbiter: list the requesters, pick by the rules, update state.
  task automatic model_step(input int u, input int n, input logic [7:0] r,
                            input logic md, input logic rdy, input logic lk,
                            output exp_t e);
    int rv;
    int win;
    rv    = int'(r) & ((1 << n) - 1);
    e.any = (rv != 0);
    if (!m_vld[u] || rdy) begin
      win = -1;
`ifdef PRI_ARB_LOCK_EN
      if (m_lk[u] && rv[m_lkidx[u]]) win = m_lkidx[u];
`endif
      if (win < 0) begin
        if (!md) begin
          for (int i = n - 1; i >= 0; i--)
            if (win < 0 && rv[i]) win = i;
        end else begin
          for (int k = 0; k < n; k++) begin
            int c;
            c = (m_ptr[u] - k + n) % n;
            if (win < 0 && rv[c]) win = c;
          end
          if (win >= 0) m_ptr[u] = (win == 0) ? n - 1 : win - 1;
        end
      end
      m_lk[u]    = (win >= 0) && lk;
      m_lkidx[u] = (win >= 0) ? win : 0;
      m_vld[u]   = (win >= 0);
      m_idx[u]   = (win >= 0) ? win : 0;
    end
    e.vld = m_vld[u];
    e.idx = m_idx[u];
    e.oh  = m_vld[u] ? (1 << m_idx[u]) : 0;
  endtask

  task automatic apply(input logic [7:0] r, input logic md, input logic rdy,
                       input logic lk);
    exp_t e;
    if4.req       = r[3:0];
    if5.req       = r[4:0];
    if4.mode      = md;
    if5.mode      = md;
    if4.out_ready = rdy;
    if5.out_ready = rdy;
`ifdef PRI_ARB_LOCK_EN
    if4.lock      = lk;
    if5.lock      = lk;
`endif
    model_step(0, 4, r, md, rdy, lk, e);
    q4.push_back(e);
    model_step(1, 5, r, md, rdy, lk, e);
    q5.push_back(e);
  endtask

  task automatic step(input logic [7:0] r, input logic md, input logic rdy,
                      input logic lk);
    @(negedge clk);
    apply(r, md, rdy, lk);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".u4.valid"},  int'(if4.out_valid),  0);
    chk({tag, ".u4.idx"},    int'(if4.out_idx),    0);
    chk({tag, ".u4.onehot"}, int'(if4.out_onehot), 0);
    chk({tag, ".u4.any"},    int'(if4.any),        0);
    chk({tag, ".u5.valid"},  int'(if5.out_valid),  0);
    chk({tag, ".u5.idx"},    int'(if5.out_idx),    0);
  endtask

  // Asynchronous reset at a point away from any clock edge, then a clean
  // synchronous release with the inputs already defined.
  task automatic mid_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk_zero("async_rst");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    apply(8'h00, 1'b0, 1'b1, 1'b0);
  endtask

  // Monitor: one expected entry per clock, compared just after the edge.
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (q4.size() > 0) begin
      e = q4.pop_front();
      chk("u4.valid",  int'(if4.out_valid),  int'(e.vld));
      chk("u4.idx",    int'(if4.out_idx),    e.idx);
      chk("u4.onehot", int'(if4.out_onehot), e.oh);
      chk("u4.any",    int'(if4.any),        int'(e.any));
    end
    if (q5.size() > 0) begin
      e = q5.pop_front();
      chk("u5.valid",  int'(if5.out_valid),  int'(e.vld));
      chk("u5.idx",    int'(if5.out_idx),    e.idx);
      chk("u5.onehot", int'(if5.out_onehot), e.oh);
      chk("u5.any",    int'(if5.any),        int'(e.any));
    end
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    if4.req = '0; if4.mode = 1'b0; if4.out_ready = 1'b0;
    if5.req = '0; if5.mode = 1'b0; if5.out_ready = 1'b0;
`ifdef PRI_ARB_LOCK_EN
    if4.lock = 1'b0; if5.lock = 1'b0;
`endif
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    chk_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    apply(8'h00, 1'b0, 1'b1, 1'b0);

    // Fixed priority, then empty request.
    step(8'b0110, 1'b0, 1'b1, 1'b0);
    step(8'b0000, 1'b0, 1'b1, 1'b0);

    // Backpressure hold while req changes; any keeps tracking.
    step(8'b1010, 1'b0, 1'b0, 1'b0);
    repeat (3) step(8'b0001, 1'b0, 1'b0, 1'b0);
    step(8'b0001, 1'b0, 1'b1, 1'b0);
    // Mode change during a hold does not disturb the held result.
    step(8'b1000, 1'b0, 1'b1, 1'b0);
    step(8'b0010, 1'b1, 1'b0, 1'b0);
    step(8'b0010, 1'b1, 1'b1, 1'b0);

    // Round-robin full rotation from the reset pointer.
    mid_reset();
    repeat (6) step(8'b1111, 1'b1, 1'b1, 1'b0);
    // Sparse rotation: wraps modulo N (N=4: 3,0,3,0 / N=5: 4,0,4).
    mid_reset();
    repeat (4) step(8'b1001, 1'b1, 1'b1, 1'b0);
    mid_reset();
    repeat (3) step(8'b10001, 1'b1, 1'b1, 1'b0);

    // Reset in the middle of a hold, then RR restarts from the top.
    step(8'b1111, 1'b1, 1'b1, 1'b0);
    step(8'b0110, 1'b0, 1'b0, 1'b0);
    mid_reset();
    repeat (2) step(8'b1111, 1'b1, 1'b1, 1'b0);

`ifdef PRI_ARB_LOCK_EN
    mid_reset();
    repeat (3) step(8'b1111, 1'b1, 1'b1, 1'b1);
    step(8'b0111, 1'b1, 1'b1, 1'b1);
    repeat (3) step(8'b0111, 1'b1, 1'b1, 1'b0);
`endif

    // Randomised traffic with mixed modes and backpressure.
    mid_reset();
    for (int i = 0; i < 400; i++) begin
      logic [7:0] r;
      logic md, rdy, lk;
      r   = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 7) == 0) r = 8'h00;
      md  = ($urandom_range(0, 2) != 0);
      rdy = ($urandom_range(0, 3) != 0);
      lk  = ($urandom_range(0, 3) == 0);
      step(r, md, rdy, lk);
    end

    @(posedge clk);
    #3;
    chk("q4.drained", q4.size(), 0);
    chk("q5.drained", q5.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
